// File: rtl/prg_saver_if.sv
// ============================================================================
// Module  : prg_saver_if
// Brief   : RAM read port and byte stream bundle between prg_saver and its
//           environment (RAM model / HPS upload sink).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface prg_saver_if;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output ram_addr, ram_rd, out_data, out_valid,
    input  ram_dout, out_ready
  );

  modport slave (
    input  ram_addr, ram_rd, out_data, out_valid,
    output ram_dout, out_ready
  );
endinterface

`default_nettype wire

// File: rtl/prg_saver.sv
// ============================================================================
// Module  : prg_saver
// Brief   : Captures the BASIC program from C16 main RAM as a PRG byte stream
//           (2-byte load address followed by bytes [start, end-1]).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prg_saver #(
  parameter logic [15:0] PTR_START = 16'h002B,
  parameter logic [15:0] PTR_END   = 16'h002D,
  parameter int          RAM_LAT   = 1
) (
  input  wire logic        clk_sys,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic        abort,
  prg_saver_if.master      bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [16:0]      byte_cnt
);

  localparam logic [1:0] c_lat = 2'(RAM_LAT);

  typedef enum logic [3:0] {
    S_IDLE, S_PTR_RD, S_PTR_WAIT, S_HDR0, S_HDR1,
    S_DAT_RD, S_DAT_WAIT, S_DAT_OUT, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_wait;
  logic [1:0]  r_idx;
  logic [15:0] r_s;
  logic [7:0]  r_e_lo;
  logic [15:0] r_cur;
  logic [15:0] r_rem;
  logic [7:0]  r_data;
  logic [15:0] r_addr_hold;
  logic [15:0] w_ptr_addr;
  logic [15:0] w_e_full;
  logic        w_lat_hit;
  logic        w_accept;
  logic        w_go;

  assign w_lat_hit = (r_wait == c_lat);
  assign w_accept  = bus.out_valid && bus.out_ready;
  assign w_go      = (r_state == S_IDLE) && start && !abort;
  assign w_e_full  = {bus.ram_dout, r_e_lo};

  always_comb begin
    case (r_idx)
      2'd0:    w_ptr_addr = PTR_START;
      2'd1:    w_ptr_addr = PTR_START + 16'd1;
      2'd2:    w_ptr_addr = PTR_END;
      default: w_ptr_addr = PTR_END + 16'd1;
    endcase
  end

  // Address is driven live during a read strobe and held afterwards.
  assign bus.ram_addr  = (r_state == S_PTR_RD) ? w_ptr_addr :
                         (r_state == S_DAT_RD) ? r_cur : r_addr_hold;
  assign bus.ram_rd    = (r_state == S_PTR_RD) || (r_state == S_DAT_RD);
  assign bus.out_valid = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                         (r_state == S_DAT_OUT);
  assign bus.out_data  = (r_state == S_HDR0)    ? r_s[7:0]  :
                         (r_state == S_HDR1)    ? r_s[15:8] :
                         (r_state == S_DAT_OUT) ? r_data    : 8'h00;
  assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done          = (r_state == S_DONE);

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start && !abort) w_state_nxt = S_PTR_RD;
      S_PTR_RD:   w_state_nxt = S_PTR_WAIT;
      S_PTR_WAIT: if (w_lat_hit) w_state_nxt = (r_idx == 2'd3) ? S_HDR0 : S_PTR_RD;
      S_HDR0:     if (w_accept) w_state_nxt = S_HDR1;
      S_HDR1:     if (w_accept) w_state_nxt = (r_rem == 16'd0) ? S_DONE : S_DAT_RD;
      S_DAT_RD:   w_state_nxt = S_DAT_WAIT;
      S_DAT_WAIT: if (w_lat_hit) w_state_nxt = S_DAT_OUT;
      S_DAT_OUT:  if (w_accept) w_state_nxt = (r_rem == 16'd1) ? S_DONE : S_DAT_RD;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wait      <= 2'd0;
      r_idx       <= 2'd0;
      r_s         <= 16'd0;
      r_e_lo      <= 8'd0;
      r_cur       <= 16'd0;
      r_rem       <= 16'd0;
      r_data      <= 8'd0;
      r_addr_hold <= 16'd0;
      err         <= 1'b0;
      byte_cnt    <= 17'd0;
    end else begin
      r_addr_hold <= bus.ram_addr;
      if (w_go) begin
        err      <= 1'b0;
        byte_cnt <= 17'd0;
        r_idx    <= 2'd0;
      end
      // Abort discards any in-flight read and leaves err/byte_cnt untouched.
      if (!abort) begin
        if (bus.ram_rd)
          r_wait <= 2'd1;
        else if (((r_state == S_PTR_WAIT) || (r_state == S_DAT_WAIT)) && !w_lat_hit)
          r_wait <= r_wait + 2'd1;

        if ((r_state == S_PTR_WAIT) && w_lat_hit) begin
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            2'd0: r_s[7:0]  <= bus.ram_dout;
            2'd1: r_s[15:8] <= bus.ram_dout;
            2'd2: r_e_lo    <= bus.ram_dout;
            default: begin
              r_cur <= r_s;
              if (w_e_full <= r_s) begin
                err   <= 1'b1;
                r_rem <= 16'd0;
              end else begin
                r_rem <= w_e_full - r_s;
              end
            end
          endcase
        end

        if ((r_state == S_DAT_WAIT) && w_lat_hit)
          r_data <= bus.ram_dout;

        if (w_accept) begin
          byte_cnt <= byte_cnt + 17'd1;
          if (r_state == S_DAT_OUT) begin
            r_cur <= r_cur + 16'd1;
            r_rem <= r_rem - 16'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prg_saver.sv
// ============================================================================
// Module  : tb_prg_saver
// Brief   : Self-checking bench for prg_saver (RAM_LAT=1 and RAM_LAT=3 copies).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prg_saver;

  localparam logic [15:0] c_PS = 16'h002B;
  localparam logic [15:0] c_PE = 16'h002D;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;
  int          ready_pct = 100;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q [$];
  logic [7:0]  d1, p1, p2, p3;

  logic        busy1, done1, err1, busy3, done3, err3;
  logic [16:0] cnt1, cnt3;

  prg_saver_if bus1();
  prg_saver_if bus3();

  prg_saver #(.PTR_START(c_PS), .PTR_END(c_PE), .RAM_LAT(1)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset),
    .start(start && !sel), .abort(abort && !sel),
    .bus(bus1), .busy(busy1), .done(done1), .err(err1), .byte_cnt(cnt1)
  );

  prg_saver #(.PTR_START(c_PS), .PTR_END(c_PE), .RAM_LAT(3)) u_dut3 (
    .clk_sys(clk_sys), .reset(reset),
    .start(start && sel), .abort(abort && sel),
    .bus(bus3), .busy(busy3), .done(done3), .err(err3), .byte_cnt(cnt3)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM models: data appears exactly RAM_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk_sys) begin
    d1 <= bus1.ram_rd ? mem[bus1.ram_addr] : 8'hEE;
    p1 <= bus3.ram_rd ? mem[bus3.ram_addr] : 8'hEE;
    p2 <= p1;
    p3 <= p2;
  end
  assign bus1.ram_dout  = d1;
  assign bus3.ram_dout  = p3;
  assign bus1.out_ready = out_ready;
  assign bus3.out_ready = out_ready;

  always @(posedge clk_sys) begin
    #1;
    out_ready = (int'($urandom_range(0, 99)) < ready_pct);
  end

  wire        m_valid = sel ? bus3.out_valid : bus1.out_valid;
  wire [7:0]  m_data  = sel ? bus3.out_data  : bus1.out_data;
  wire        m_rd    = sel ? bus3.ram_rd    : bus1.ram_rd;
  wire [15:0] m_addr  = sel ? bus3.ram_addr  : bus1.ram_addr;
  wire        m_busy  = sel ? busy3 : busy1;
  wire        m_done  = sel ? done3 : done1;
  wire        m_err   = sel ? err3  : err1;
  wire [16:0] m_cnt   = sel ? cnt3  : cnt1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Stream monitor: pops the scoreboard on each accepted byte.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  always @(negedge clk_sys) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && m_valid) chk("hold_stable", 32'(m_data), 32'(hold_data));
      hold_pend = m_valid && !out_ready;
      hold_data = m_data;
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte actual=%0h required=none", m_data);
        end else begin
          chk("stream_byte", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      if (!m_busy) chk("rd_idle", 32'(m_rd), 32'd0);
    end
  end

  task automatic load_ptrs(input logic [15:0] s, input logic [15:0] e);
    mem[c_PS]         = s[7:0];
    mem[c_PS + 16'd1] = s[15:8];
    mem[c_PE]         = e[7:0];
    mem[c_PE + 16'd1] = e[15:8];
    exp_q.delete();
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
    if (e > s)
      for (int a = int'(s); a < int'(e); a++) exp_q.push_back(mem[a]);
  endtask

  task automatic pulse_start(input string nm);
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
    chk({nm, "_busy_after_start"}, 32'(m_busy), 32'd1);
  endtask

  task automatic wait_cnt(input string nm, input logic [16:0] target);
    logic hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_sys);
      if (m_cnt == target) begin hit = 1'b1; break; end
    end
    chk({nm, "_reach_cnt"}, 32'(hit), 32'd1);
  endtask

  task automatic run(input logic lat3, input logic [15:0] s, input logic [15:0] e,
                     input int rp, input logic exp_err, input logic [16:0] exp_cnt,
                     input string nm, input int restart_at);
    int   len;
    int   budget;
    logic got = 1'b0;
    sel = lat3;
    ready_pct = rp;
    load_ptrs(s, e);
    len = (e > s) ? int'(e) - int'(s) : 0;
    budget = 400 + (len + 2) * (lat3 ? 5 : 3) * ((rp < 100) ? 8 : 2);
    pulse_start(nm);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_sys);
      start = (c == restart_at);
      if (m_done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(m_busy), 32'd0);
    chk({nm, "_err"}, 32'(m_err), 32'(exp_err));
    chk({nm, "_byte_cnt"}, 32'(m_cnt), 32'(exp_cnt));
    chk({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk_sys);
    chk({nm, "_done_one_cycle"}, 32'(m_done), 32'd0);
    chk({nm, "_err_kept"}, 32'(m_err), 32'(exp_err));
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},  32'(m_busy),  32'd0);
    chk({nm, "_done"},  32'(m_done),  32'd0);
    chk({nm, "_err"},   32'(m_err),   32'd0);
    chk({nm, "_cnt"},   32'(m_cnt),   32'd0);
    chk({nm, "_valid"}, 32'(m_valid), 32'd0);
    chk({nm, "_data"},  32'(m_data),  32'd0);
    chk({nm, "_rd"},    32'(m_rd),    32'd0);
    chk({nm, "_addr"},  32'(m_addr),  32'd0);
  endtask

  typedef struct {
    logic        lat3;
    logic [15:0] s;
    logic [15:0] e;
    int          rp;
    logic        exp_err;
    logic [16:0] exp_cnt;
    string       nm;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic seen;
    vecs[0] = '{1'b0, 16'h1001, 16'h1004, 100, 1'b0, 17'd5,    "T1_basic"};
    vecs[1] = '{1'b0, 16'h1001, 16'h1004, 50,  1'b0, 17'd5,    "T2_rand_ready"};
    vecs[2] = '{1'b0, 16'h1001, 16'h1001, 100, 1'b1, 17'd2,    "T3_empty"};
    vecs[3] = '{1'b0, 16'h1004, 16'h1001, 100, 1'b1, 17'd2,    "end_below_start"};
    vecs[4] = '{1'b0, 16'h2000, 16'h2001, 70,  1'b0, 17'd3,    "one_byte"};
    vecs[5] = '{1'b1, 16'h1001, 16'h1004, 50,  1'b0, 17'd5,    "lat3_basic"};
    vecs[6] = '{1'b1, 16'hF000, 16'hFFFF, 100, 1'b0, 17'd4097, "T6_top_of_ram"};

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    mem[16'h1001] = 8'hAA;
    mem[16'h1002] = 8'hBB;
    mem[16'h1003] = 8'hCC;

    repeat (3) @(posedge clk_sys);
    #1 start = 1'b1;
    @(posedge clk_sys); #1;
    chk_all_zero("reset");
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run(vecs[i].lat3, vecs[i].s, vecs[i].e, vecs[i].rp, vecs[i].exp_err,
          vecs[i].exp_cnt, vecs[i].nm, -1);

    // T4: abort after the second data byte, then a clean replay.
    sel = 1'b0;
    ready_pct = 100;
    load_ptrs(16'h1001, 16'h1004);
    pulse_start("T4");
    wait_cnt("T4", 17'd4);
    @(posedge clk_sys); #1 abort = 1'b1;
    @(posedge clk_sys); #1 abort = 1'b0;
    chk("T4_abort_busy",  32'(m_busy),  32'd0);
    chk("T4_abort_valid", 32'(m_valid), 32'd0);
    chk("T4_abort_cnt",   32'(m_cnt),   32'd4);
    chk("T4_abort_err",   32'(m_err),   32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_sys);
      if (m_done || m_valid) seen = 1'b1;
    end
    chk("T4_no_done_after_abort", 32'(seen), 32'd0);
    chk("T4_unsent_bytes", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    run(1'b0, 16'h1001, 16'h1004, 100, 1'b0, 17'd5, "T4_replay", -1);

    // start and abort together in IDLE: abort wins.
    @(posedge clk_sys); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", 32'(m_busy), 32'd0);
    chk("start_abort_idle_rd",   32'(m_rd),   32'd0);

    // T5: reset mid-DATA with a byte on offer, then start-while-busy ignored.
    load_ptrs(16'h1001, 16'h1004);
    pulse_start("T5");
    wait_cnt("T5", 17'd3);
    ready_pct = 0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_sys);
      if (m_valid) begin seen = 1'b1; break; end
    end
    chk("T5_valid_before_reset", 32'(seen), 32'd1);
    @(posedge clk_sys); #1 reset = 1'b1;
    @(posedge clk_sys); #1;
    chk_all_zero("T5_reset");
    reset = 1'b0;
    exp_q.delete();
    run(1'b0, 16'h1001, 16'h1004, 100, 1'b0, 17'd5, "T5_restart_ignored", 12);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_sys);
      if (m_busy || m_valid) seen = 1'b1;
    end
    chk("T5_no_second_capture", 32'(seen), 32'd0);

    run(vecs[6].lat3, vecs[6].s, vecs[6].e, vecs[6].rp, vecs[6].exp_err,
        vecs[6].exp_cnt, vecs[6].nm, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
